// File: rtl/mmu_rr_arb.sv
// mmu_rr_arb: funnels RPORT read and WPORT write ports onto one memory request interface,
// round-robin within a class, read/write alternation between classes. Optional macro: MMU_TIMEOUT_EN.
module mmu_rr_arb #(
  parameter int RPORT   = 2,
  parameter int WPORT   = 1,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RPORT-1:0]          co_re,
  input  logic [RPORT*ADDR_W-1:0]   co_raddr,
  input  logic [RPORT*LEN_W-1:0]    co_rlen,
  output logic [RPORT*DATA_W-1:0]   co_din,
  output logic [RPORT-1:0]          co_rack,
  input  logic [WPORT-1:0]          co_we,
  input  logic [WPORT*ADDR_W-1:0]   co_waddr,
  input  logic [WPORT*LEN_W-1:0]    co_wlen,
  input  logic [WPORT*DATA_W-1:0]   co_dout,
  output logic [WPORT-1:0]          co_wack,
  output logic                      c_re,
  output logic                      c_we,
  output logic [ADDR_W-1:0]         addr,
  output logic [LEN_W-1:0]          len,
  output logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rdata,
  input  logic                      m_rack,
  input  logic                      m_wack,
  output logic                      busy,
  output logic                      err
);
  localparam int RP_W = (RPORT > 1) ? $clog2(RPORT) : 1;
  localparam int WP_W = (WPORT > 1) ? $clog2(WPORT) : 1;
  localparam int ID_W = (RP_W > WP_W) ? RP_W : WP_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]        r_state;
  logic [RP_W-1:0]   r_rptr;
  logic [WP_W-1:0]   r_wptr;
  logic              r_last_wr;
  logic              r_cls_wr;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_wdata;
  logic [RPORT*DATA_W-1:0] r_din;

  logic [2*RPORT-1:0] w_rrot;
  logic [2*WPORT-1:0] w_wrot;
  logic              w_rfound, w_wfound, w_pick_wr, w_tmo;
  logic [ID_W-1:0]   w_rid, w_wid;
  logic [ADDR_W-1:0] w_gaddr;
  logic [LEN_W-1:0]  w_glen;
  logic [DATA_W-1:0] w_gdata;

  // Rotate so bit j is port (ptr+1+j) mod N; the lowest set bit is the round-robin winner.
  assign w_rrot = {co_re, co_re} >> (int'(r_rptr) + 1);
  assign w_wrot = {co_we, co_we} >> (int'(r_wptr) + 1);

  always_comb begin
    w_rfound = 1'b0;
    w_rid    = '0;
    for (int j = 0; j < RPORT; j++) begin
      if (!w_rfound && w_rrot[j]) begin
        w_rfound = 1'b1;
        w_rid    = ID_W'((int'(r_rptr) + 1 + j) % RPORT);
      end
    end
    w_wfound = 1'b0;
    w_wid    = '0;
    for (int j = 0; j < WPORT; j++) begin
      if (!w_wfound && w_wrot[j]) begin
        w_wfound = 1'b1;
        w_wid    = ID_W'((int'(r_wptr) + 1 + j) % WPORT);
      end
    end
  end

  assign w_pick_wr = w_wfound && (!w_rfound || !r_last_wr);

  always_comb begin
    w_gaddr = '0;
    w_glen  = '0;
    w_gdata = '0;
    if (w_pick_wr) begin
      for (int i = 0; i < WPORT; i++) begin
        if (w_wid == ID_W'(i)) begin
          w_gaddr = co_waddr[i*ADDR_W +: ADDR_W];
          w_glen  = co_wlen[i*LEN_W +: LEN_W];
          w_gdata = co_dout[i*DATA_W +: DATA_W];
        end
      end
    end else begin
      for (int i = 0; i < RPORT; i++) begin
        if (w_rid == ID_W'(i)) begin
          w_gaddr = co_raddr[i*ADDR_W +: ADDR_W];
          w_glen  = co_rlen[i*LEN_W +: LEN_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_last_wr <= 1'b1;
      r_cls_wr  <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_wdata   <= '0;
      r_din     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rfound || w_wfound) begin
            r_cls_wr <= w_pick_wr;
            r_id     <= w_pick_wr ? w_wid : w_rid;
            r_addr   <= w_gaddr;
            r_len    <= w_glen;
            r_wdata  <= w_gdata;
            r_state  <= w_pick_wr ? S_WR : S_RD;
          end
        end
        S_RD: begin
          if (m_rack || w_tmo) begin
            for (int i = 0; i < RPORT; i++) begin
              if (r_id == ID_W'(i)) r_din[i*DATA_W +: DATA_W] <= m_rack ? rdata : '0;
            end
            r_state <= S_ACK;
          end
        end
        S_WR: begin
          if (m_wack || w_tmo) r_state <= S_ACK;
        end
        default: begin
          if (r_cls_wr) r_wptr <= r_id[WP_W-1:0];
          else          r_rptr <= r_id[RP_W-1:0];
          r_last_wr <= r_cls_wr;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < RPORT; i++)
      co_rack[i] = (r_state == S_ACK) && !r_cls_wr && (r_id == ID_W'(i));
    for (int i = 0; i < WPORT; i++)
      co_wack[i] = (r_state == S_ACK) && r_cls_wr && (r_id == ID_W'(i));
  end

  assign c_re   = (r_state == S_RD);
  assign c_we   = (r_state == S_WR);
  assign busy   = c_re || c_we;
  assign addr   = r_addr;
  assign len    = r_len;
  assign wdata  = r_wdata;
  assign co_din = r_din;

`ifdef MMU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // The counter sits at 0 in the first RD/WR cycle, so TIMEOUT-1 marks the last waiting cycle.
  assign w_tmo = ((c_re && !m_rack) || (c_we && !m_wack)) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (busy) r_cnt <= r_cnt + 1'b1;
      else      r_cnt <= '0;
      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

endmodule
